// File: rtl/spi_mem_slave.sv
// spi_mem_slave
//   SPI slave with an internal register memory. Frames are
//   <cmd bit><ADDR_W address bits><N x DATA_W data bits>, all MSB first,
//   and last while cs stays low. cmd=1 writes, cmd=0 reads. Bursts
//   auto-increment the address and wrap modulo 2**ADDR_W. Everything runs
//   on SCLK: the SPI pins are synchronised and spi_clk edges are found by
//   oversampling.
//
// Ports
//   SCLK       system clock, all logic on its rising edge
//   SRESET     synchronous active-high reset (memory contents are kept)
//   spi_clk    SPI clock from the master, asynchronous to SCLK
//   cs         chip select, active low
//   mosi       master out / slave in
//   miso       master in / slave out (0 whenever no read data is shifting)
//   busy       high while a frame is in progress
//   wr_strobe  one-cycle pulse per committed write word
//   wr_addr    address of the committed word, valid with wr_strobe
//   wr_data    committed data word, valid with wr_strobe
//   frame_err  one-cycle pulse when cs rises in the middle of a field

module spi_mem_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 7,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              SCLK,
    input  logic              SRESET,
    input  logic              spi_clk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              busy,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err
);

    localparam int MAX_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic             IDLE_CLK       = 1'(CPOL);
    localparam bit               SAMPLE_ON_RISE = (((CPOL ^ CPHA) & 1) == 0);
    localparam logic [2:0]       FLUSH_LEN      = 3'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] ADDR_LAST_CNT  = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST_CNT  = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE      = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   cs_prev;
    logic [2:0]             flush_cnt;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic det_en;
    logic sclk_rise;
    logic sclk_fall;
    logic sample_evt;
    logic shift_evt;
    logic cs_fall;
    logic cs_rise;

    // NOTE: every clocked process assigns its state with <= so all flops
    // update from the same pre-edge values; = here would create ordering
    // races between processes.
    always_ff @(posedge SCLK) begin
        if (SRESET) begin
            sclk_sync <= {SYNC_STAGES{IDLE_CLK}};
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= IDLE_CLK;
            cs_prev   <= 1'b1;
            flush_cnt <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            cs_prev   <= cs_sync[SYNC_STAGES-1];
            if (flush_cnt != FLUSH_LEN) begin
                flush_cnt <= flush_cnt + 3'd1;
            end
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // The synchroniser reset values are not the real pin levels. Edges are
    // ignored until the chain and the edge flops hold true pin values, so a
    // cs that is already low after reset is not mistaken for a new frame.
    assign det_en = (flush_cnt == FLUSH_LEN);

    assign sclk_rise  = det_en &  sclk_s & ~sclk_prev;
    assign sclk_fall  = det_en & ~sclk_s &  sclk_prev;
    assign sample_evt = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
    assign shift_evt  = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;
    assign cs_fall    = det_en & ~cs_s &  cs_prev;
    assign cs_rise    = det_en &  cs_s & ~cs_prev;

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] bit_cnt;
    logic             is_write;

    logic cmd_take;
    logic addr_take;
    logic addr_last;
    logic data_take;
    logic data_last;
    logic abort_err;

    always_ff @(posedge SCLK) begin
        if (SRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default before any branch;
    // a signal left unassigned on some path would infer a latch.
    always_comb begin
        state_d   = state_q;
        cmd_take  = 1'b0;
        addr_take = 1'b0;
        addr_last = 1'b0;
        data_take = 1'b0;
        data_last = 1'b0;
        abort_err = 1'b0;

        if (cs_rise) begin
            // cs rise wins over a sample detected in the same cycle.
            state_d   = ST_IDLE;
            abort_err = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                        ((state_q == ST_DATA) && (bit_cnt != '0));
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (sample_evt) begin
                        cmd_take = 1'b1;
                        state_d  = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (sample_evt) begin
                        addr_take = 1'b1;
                        if (bit_cnt == ADDR_LAST_CNT) begin
                            addr_last = 1'b1;
                            state_d   = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (sample_evt) begin
                        data_take = 1'b1;
                        data_last = (bit_cnt == DATA_LAST_CNT);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register memory
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] addr_sr;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] data_sr;
    logic [DATA_W-1:0] data_next;
    logic [DATA_W-1:0] shift_out;
    logic              mem_we;

    assign addr_next = (addr_sr << 1) | ADDR_W'(mosi_s);
    assign data_next = (data_sr << 1) | DATA_W'(mosi_s);
    assign addr_inc  = cur_addr + ADDR_ONE;  // wraps naturally at 2**ADDR_W
    assign mem_we    = data_last & is_write & ~SRESET;

    // NOTE: the memory has no reset branch; its contents deliberately
    // survive SRESET, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge SCLK) begin
        if (mem_we) begin
            mem[cur_addr] <= data_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge SCLK) begin
        if (SRESET) begin
            miso      <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            bit_cnt   <= '0;
            is_write  <= 1'b0;
            cur_addr  <= '0;
            addr_sr   <= '0;
            data_sr   <= '0;
            shift_out <= '0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= abort_err;
            busy      <= (state_d != ST_IDLE);

            if (cmd_take) begin
                is_write <= mosi_s;
                bit_cnt  <= '0;
            end

            if (addr_take) begin
                addr_sr <= addr_next;
                if (addr_last) begin
                    bit_cnt  <= '0;
                    cur_addr <= addr_next;
                    if (!is_write) begin
                        shift_out <= mem[addr_next];
                    end
                end else begin
                    bit_cnt <= bit_cnt + CNT_ONE;
                end
            end

            if (data_take) begin
                data_sr <= data_next;
                if (data_last) begin
                    bit_cnt  <= '0;
                    cur_addr <= addr_inc;
                    if (is_write) begin
                        wr_strobe <= 1'b1;
                        wr_addr   <= cur_addr;
                        wr_data   <= data_next;
                    end else begin
                        // Prefetch the next burst word so its MSB is ready
                        // for the very next shift edge.
                        shift_out <= mem[addr_inc];
                    end
                end else begin
                    bit_cnt   <= bit_cnt + CNT_ONE;
                    shift_out <= shift_out << 1;
                end
            end

            // miso only carries data during the data phase of a read.
            if ((state_d != ST_DATA) || is_write) begin
                miso <= 1'b0;
            end else if (shift_evt) begin
                miso <= shift_out[DATA_W-1];
            end
        end
    end

endmodule

// File: doc/spi_mem_slave.md
# spi_mem_slave

Parametrised SPI slave with an internal register memory. It supports all four SPI modes, configurable data/address widths and multi-word burst transfers with address auto-increment. It runs entirely in the SCLK domain; the SPI pins are synchronised and spi_clk edges are detected by oversampling. It is the target-side counterpart of the AHB-to-SPI bridge and the drop-in replacement for the fixed 32-bit/7-bit single-word slave.

## Interface
Parameters:
- DATA_W, 32: data word width in bits (8..64).
- ADDR_W, 7: address width; memory depth is 2**ADDR_W words.
- CPOL, 0: SPI clock idle level.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- SYNC_STAGES, 2: synchroniser depth on spi_clk, cs and mosi (2..3).

Ports:
- SCLK  in  1  system clock; all logic on its rising edge.
- SRESET  in  1  synchronous, active-high reset.
- spi_clk  in  1  SPI clock from master, asynchronous to SCLK.
- cs  in  1  chip select, active low.
- mosi  in  1  master out, slave in; MSB first.
- miso  out  1  master in, slave out; MSB first.
- busy  out  1  high from cs-fall detection until cs-rise detection.
- wr_strobe  out  1  one-cycle pulse per committed write word.
- wr_addr  out  ADDR_W  address of the committed word; valid with wr_strobe.
- wr_data  out  DATA_W  committed data; valid with wr_strobe.
- frame_err  out  1  one-cycle pulse when a frame ends mid-field.

## Operation
- Frame format, all fields MSB first:
  - 1 command bit: 1 = write, 0 = read.
  - ADDR_W address bits.
  - N ≥ 1 data words of DATA_W bits each, for as long as cs stays low.
- Sample edge: rising when CPOL^CPHA = 0, falling otherwise. Shift (drive) edge is the opposite edge. Both are detected on the synchronised spi_clk.
- State machine:
  - IDLE -> CMD on a detected cs falling edge; a cs level alone does not start a frame.
  - CMD -> ADDR after 1 sample.
  - ADDR -> DATA after ADDR_W samples.
  - DATA loops per word.
  - Any state -> IDLE on a detected cs rising edge.
- Address phase, last sample: latch cur_addr. For a read, load shift_out <= mem[cur_addr].
- Write, at each word's last sample:
  - mem[cur_addr] <= received word.
  - Pulse wr_strobe with wr_addr/wr_data.
  - cur_addr <= cur_addr+1, wrapping modulo 2**ADDR_W (max address -> 0).
- Read:
  - miso <= shift_out MSB on each shift edge in DATA; shift_out shifts left on each sample.
  - At each word's last sample: cur_addr increments (same wrap) and shift_out <= mem[cur_addr+1] (prefetch).
- miso drives 0 in IDLE, CMD, ADDR, and throughout write frames.
- cs rise mid-field (in CMD/ADDR, or DATA with a partial word):
  - Partial word discarded, no memory write.
  - frame_err pulses.
  - A clean end on a word boundary gives no error.
- A cs rise with 0 data words after a complete address gives no error and no write.
- Memory is not cleared by reset; contents persist across SRESET.
- Reset mid-frame: state to IDLE and outputs to reset values. The frame in progress is ignored until the next detected cs falling edge.

## Timing
- Reset values:
  - miso = 0, busy = 0, wr_strobe = 0, frame_err = 0.
  - wr_addr = 0, wr_data = 0.
  - Synchroniser flops = 1 for cs, CPOL for spi_clk, 0 for mosi.
- Pin-to-detect latency: SYNC_STAGES+1 SCLK cycles for spi_clk/cs edges.
- miso changes 1 SCLK after its shift edge is detected.
- wr_strobe asserts 1 SCLK after the last data sample is detected.
- busy rises 1 cycle after cs-fall detection and falls 1 cycle after cs-rise detection.
- Master constraints:
  - spi_clk high and low times ≥ SYNC_STAGES+3 SCLK cycles.
  - cs setup to first spi_clk edge ≥ SYNC_STAGES+3 SCLK cycles.
  - cs high time between frames ≥ SYNC_STAGES+3 SCLK cycles.
- cs rise and a sample detected in the same cycle: the sample is dropped and the cs rise wins.

## Test plan
- Defaults, mode 0: write frame cmd=1, addr=0x05, data=0xDEADBEEF -> one wr_strobe with wr_addr=0x05, wr_data=0xDEADBEEF; miso stays 0; frame_err never pulses.
- Read back addr 0x05 in modes 0, 1, 2, 3 (CPOL/CPHA parameter sweep) -> master captures 0xDEADBEEF on miso in every mode.
- Burst write at addr 0x7F with words 0x11111111, 0x22222222 -> wr_addr 0x7F then 0x00 (wrap). A burst read from 0x7F then returns both words in order.
- Write frame aborted after 16 data bits -> frame_err pulses once, no wr_strobe, memory word unchanged on read-back.
- SRESET asserted mid-read with cs held low -> miso=0 and busy=0 next cycle; slave ignores the rest of the frame; the next full frame after cs high-then-low completes correctly.
- DATA_W=8, ADDR_W=4 instance: write 0xA5 at addr 0x3, read back -> 0xA5; frame length is 13 bits per single-word transfer.
